// File: rtl/knn_pkg.sv
// Shared definitions for the kNN vote stage: FSM encoding, parameter defaults
// and the class-count helper.
package knn_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CLASS_BITS_DEF = 4;
    localparam int VOTE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    // Number of distinct class labels carried in cb label bits.
    function automatic int num_classes(input int cb);
        return 1 << cb;
    endfunction

endpackage

// File: rtl/knn_vote_if.sv
// Query/result stream in, classification out over a valid/ready handshake.
interface knn_vote_if
    import knn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH_DEF,
    parameter int classBits = CLASS_BITS_DEF,
    parameter int voteWidth = VOTE_WIDTH_DEF
);
    logic                 start;
    logic [31:0]          k;
    logic                 resultValid;
    logic [31:0]          dataNameIn;
    logic [dataWidth-1:0] dataValueIn;
    logic                 busy;
    logic                 classValid;
    logic                 classReady;
    logic [classBits-1:0] classOut;
    logic [voteWidth-1:0] classVotes;
    logic [dataWidth-1:0] nearestDist;
    logic                 noVote;

    // Vote block side.
    modport slave (
        input  start, k, resultValid, dataNameIn, dataValueIn, classReady,
        output busy, classValid, classOut, classVotes, nearestDist, noVote
    );

    // Sorter/host side.
    modport master (
        output start, k, resultValid, dataNameIn, dataValueIn, classReady,
        input  busy, classValid, classOut, classVotes, nearestDist, noVote
    );

endinterface

// File: rtl/knn_vote_table.sv
// Per-class saturating vote counters plus the distance of the first (nearest)
// neighbour seen for each class. Synchronous clear, one increment port, one
// combinational read port.
module knn_vote_table
    import knn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH_DEF,
    parameter int classBits = CLASS_BITS_DEF,
    parameter int voteWidth = VOTE_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_en,
    input  logic [classBits-1:0] inc_label,
    input  logic [dataWidth-1:0] inc_dist,
    input  logic [classBits-1:0] rd_idx,
    output logic [voteWidth-1:0] rd_votes,
    output logic [dataWidth-1:0] rd_dist
);

    localparam int NC = num_classes(classBits);

    logic [voteWidth-1:0] vote_q [NC];
    logic [voteWidth-1:0] vote_d [NC];
    logic [dataWidth-1:0] dist_q [NC];
    logic [dataWidth-1:0] dist_d [NC];

    // Clear on query start; otherwise count the incoming label, saturating,
    // and capture its distance when it is the first vote for that class.
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            vote_d[i] = vote_q[i];
            dist_d[i] = dist_q[i];
        end
        if (clr) begin
            for (int i = 0; i < NC; i++) begin
                vote_d[i] = '0;
                dist_d[i] = '0;
            end
        end else if (inc_en) begin
            if (vote_q[inc_label] != '1) begin
                vote_d[inc_label] = vote_q[inc_label] + 1'b1;
            end
            if (vote_q[inc_label] == '0) begin
                dist_d[inc_label] = inc_dist;
            end
        end
    end

    // Table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                vote_q[i] <= '0;
                dist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                vote_q[i] <= vote_d[i];
                dist_q[i] <= dist_d[i];
            end
        end
    end

    assign rd_votes = vote_q[rd_idx];
    assign rd_dist  = dist_q[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the k nearest neighbours: collect votes, scan classes
// one per cycle for the winner, then hold the result until the host takes it.
module knn_vote
    import knn_pkg::*;
#(
    parameter int dataWidth = DATA_WIDTH_DEF,
    parameter int classBits = CLASS_BITS_DEF,
    parameter int voteWidth = VOTE_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    knn_vote_if.slave  bus
);

    state_t               state_q, state_d;
    logic [31:0]          k_q, k_d;
    logic [31:0]          acc_q, acc_d;
    logic [classBits-1:0] idx_q, idx_d;
    logic [classBits-1:0] best_q, best_d;
    logic [voteWidth-1:0] best_votes_q, best_votes_d;
    logic [dataWidth-1:0] best_dist_q, best_dist_d;
    logic [classBits-1:0] out_class_q, out_class_d;
    logic [voteWidth-1:0] out_votes_q, out_votes_d;
    logic [dataWidth-1:0] out_dist_q, out_dist_d;
    logic                 no_vote_q, no_vote_d;

    logic                 accept;
    logic                 tbl_clr;
    logic [voteWidth-1:0] rd_votes;
    logic [dataWidth-1:0] rd_dist;
    logic                 replace;
    logic                 name_unused;

    // Only the label bits of the neighbour name matter here.
    assign name_unused = ^bus.dataNameIn[31:classBits];

    assign accept  = (state_q == ST_COLLECT) && bus.resultValid;
    assign tbl_clr = (state_q == ST_IDLE) && bus.start;

    knn_vote_table #(
        .dataWidth (dataWidth),
        .classBits (classBits),
        .voteWidth (voteWidth)
    ) u_table (
        .clk       (clk),
        .rst       (reset),
        .clr       (tbl_clr),
        .inc_en    (accept),
        .inc_label (bus.dataNameIn[classBits-1:0]),
        .inc_dist  (bus.dataValueIn),
        .rd_idx    (idx_q),
        .rd_votes  (rd_votes),
        .rd_dist   (rd_dist)
    );

    // Scan comparator: more votes wins; equal nonzero votes go to the nearer
    // first neighbour; a full tie keeps the earlier (lower) class. best_dist_q
    // mirrors firstDist[best], which is frozen during the scan.
    assign replace = (rd_votes > best_votes_q) ||
                     ((rd_votes == best_votes_q) && (rd_votes != '0) &&
                      (rd_dist < best_dist_q));

    // Next-state and datapath update for the four-state query FSM.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_votes_d = best_votes_q;
        best_dist_d  = best_dist_q;
        out_class_d  = out_class_q;
        out_votes_d  = out_votes_q;
        out_dist_d   = out_dist_q;
        no_vote_d    = no_vote_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    k_d   = bus.k;
                    acc_d = '0;
                    if (bus.k == 32'd0) begin
                        state_d     = ST_OUTPUT;
                        no_vote_d   = 1'b1;
                        out_class_d = '0;
                        out_votes_d = '0;
                        out_dist_d  = '0;
                    end else begin
                        state_d   = ST_COLLECT;
                        no_vote_d = 1'b0;
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.resultValid) begin
                    acc_d = acc_q + 32'd1;
                    if (acc_q == k_q - 32'd1) begin
                        state_d      = ST_DECIDE;
                        idx_d        = '0;
                        best_d       = '0;
                        best_votes_d = '0;
                        best_dist_d  = '0;
                    end
                end
            end
            ST_DECIDE: begin
                if (replace) begin
                    best_d       = idx_q;
                    best_votes_d = rd_votes;
                    best_dist_d  = rd_dist;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d     = ST_OUTPUT;
                    out_class_d = replace ? idx_q    : best_q;
                    out_votes_d = replace ? rd_votes : best_votes_q;
                    out_dist_d  = replace ? rd_dist  : best_dist_q;
                end
            end
            ST_OUTPUT: begin
                if (bus.classReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            best_votes_q <= '0;
            best_dist_q  <= '0;
            out_class_q  <= '0;
            out_votes_q  <= '0;
            out_dist_q   <= '0;
            no_vote_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            best_votes_q <= best_votes_d;
            best_dist_q  <= best_dist_d;
            out_class_q  <= out_class_d;
            out_votes_q  <= out_votes_d;
            out_dist_q   <= out_dist_d;
            no_vote_q    <= no_vote_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.classValid  = (state_q == ST_OUTPUT);
    assign bus.noVote      = no_vote_q && (state_q == ST_OUTPUT);
    assign bus.classOut    = out_class_q;
    assign bus.classVotes  = out_votes_q;
    assign bus.nearestDist = out_dist_q;

endmodule

// File: doc/knn_vote.md
# knn_vote

Consumes the ascending-distance result stream that the k-sorting stage shifts out after `done` and reduces it to one classification. The block sits downstream of the kNN top and takes the sorted `(dataName, distance)` pairs as input. It counts one vote per neighbour for the class label carried in the low bits of each data name. It then hands the winning class, its vote count and its nearest distance to the host over a valid/ready handshake.

## Interface
Parameters:
- `dataWidth`, 32, width of the distance values.
- `classBits`, 4, width of the class label; `numClasses = 2**classBits`.
- `voteWidth`, 16, width of each per-class vote counter.

Ports:
- `clk`, input, 1, single clock. All logic is rising-edge.
- `reset`, input, 1, asynchronous and active-high.
- `start`, input, 1, one-cycle pulse issued together with the sorter's `done`. Ignored unless the block is IDLE.
- `k`, input, 32, number of results to accept. Sampled on the cycle `start` is accepted.
- `resultValid`, input, 1, qualifies `dataNameIn` and `dataValueIn`.
- `dataNameIn`, input, 32, neighbour name. The class label is `dataNameIn[classBits-1:0]`.
- `dataValueIn`, input, dataWidth, neighbour distance. The stream is ascending.
- `busy`, output, 1, high in every state other than IDLE.
- `classValid`, output, 1, result available.
- `classReady`, input, 1, host accepts the result.
- `classOut`, output, classBits, winning class.
- `classVotes`, output, voteWidth, vote count of the winning class.
- `nearestDist`, output, dataWidth, distance of the first (nearest) neighbour belonging to the winning class.
- `noVote`, output, 1, high with `classValid` when `k == 0`.

Reset values: every output is 0, all counters are 0, and the state is IDLE.

## Operation
The block has four states: IDLE, COLLECT, DECIDE, OUTPUT.

- **IDLE**
  - On `start`: clear all vote counters and first-distance registers, latch `k`, and clear `acceptCnt`.
  - If `k == 0`, go to OUTPUT with `noVote = 1` and `classOut`, `classVotes` and `nearestDist` all 0.
  - Otherwise go to COLLECT.
- **COLLECT**
  - Each cycle with `resultValid` high:
    - Increment `vote[label]`. The counter saturates at all-ones; it never wraps.
    - If this is the first vote for that label, store `dataValueIn` in `firstDist[label]`.
    - Increment `acceptCnt`.
  - When the accepted result is number `k` (`acceptCnt == k-1` at that edge), go to DECIDE with `idx = 0`, `best = 0` and `bestVotes = 0`.
  - `resultValid` low means a stall. The block has no timeout.
- **DECIDE** scans one class per cycle, `idx` running from 0 to `numClasses-1`. Class `idx` replaces `best` only if one of these holds:
  - `vote[idx] > bestVotes`, or
  - `vote[idx] == bestVotes` and `vote[idx] != 0` and `firstDist[idx] < firstDist[best]`.
  - Equal votes with equal distance keep the lower index.
  - After `idx == numClasses-1`, go to OUTPUT.
- **OUTPUT**
  - `classValid` is high.
  - `classOut`, `classVotes` and `nearestDist` are held stable.
  - On `classValid && classReady`, `classValid` drops and the state returns to IDLE on the same edge.
- Results arriving outside COLLECT, or beyond `k`, are ignored and have no side effects.
- `start` while busy is ignored, and the block does not flag an error.
- Reset asserted in any state clears everything immediately. `classValid` drops asynchronously.

## Timing
- `start` sampled at edge t: `busy` is high after t, and the first result is accepted at edge t+1 at the earliest.
- Last result accepted at edge t: DECIDE covers edges t+1 through t+numClasses, and `classValid` is high after edge t+numClasses. With the defaults that is 16 cycles.
- `k == 0`: `classValid` is high after the `start` edge, with 1 cycle latency.
- With `classReady` held high, `classValid` is high for exactly 1 cycle.
- If `start` arrives in the same cycle as the handshake completes, it is ignored because the state is still OUTPUT.
- Throughput: k + numClasses + 2 cycles per query, minimum.

## Structure
- `knn_pkg` holds:
  - the state encoding (IDLE, COLLECT, DECIDE, OUTPUT);
  - the `classBits` and `voteWidth` defaults;
  - the `numClasses` helper.
- One sub-module, `knn_vote_table`:
  - holds `numClasses` saturating vote counters and first-distance registers;
  - has a synchronous clear;
  - has an increment port indexed by label;
  - has a combinational read port indexed by `idx`.
- FSM, scan comparator and output registers live in `knn_vote`.

## Test plan
- **Single majority:** `k=5`, labels 3,3,7,3,7 with distances 1,2,3,4,5 → `classOut=3`, `classVotes=3`, `nearestDist=1`, and `classValid` asserted 16 cycles after the fifth result.
- **Tie-break on distance:** `k=4`, labels 2(10), 5(11), 5(12), 2(13) → `classOut=2`, `classVotes=2`, `nearestDist=10`.
- **Zero k:** `start` with `k=0` → `classValid=1` and `noVote=1` after 1 cycle, with `classOut=0`.
- **Stall and overrun:** `k=3` with `resultValid` gapped 2 cycles between results, then 2 extra results labelled 9 → `classOut` is unaffected by label 9 and `busy` stays high through the gaps.
- **Backpressure and re-start:** hold `classReady=0` for 5 cycles, pulse `start` during OUTPUT, then raise `classReady` → outputs stay stable, the `start` is ignored, and the block returns to IDLE after one handshake.
- **Reset mid-COLLECT:** assert `reset` after 2 of 6 results → all outputs are 0 immediately. A new query with `k=1`, label 4 → `classOut=4`, `classVotes=1`, with no stale votes.
